vp_ctrl: RTL
============

# vp_ctrl

Frame-synchronous controller for the `vp` video-processing pipeline. It sits on the same `clk`/`de_in`/`h_sync_in`/`v_sync_in` stream that feeds `vp`, tracks pixel coordinates, measures active frame geometry and reports lock. It also holds double-buffered processing configuration that is applied only at frame boundaries, so `vp` never changes mode mid-frame.

## Interface

Parameters:
- `H_BITS`, 11, width of column counter and `frame_width`
- `V_BITS`, 11, width of line counter and `frame_height`
- `LOCK_FRAMES`, 2, consecutive identical-geometry frames required to assert `locked` (range 1..15)

Ports:
- `clk`  in  1  pixel clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `de_in`  in  1  data enable of incoming stream
- `h_sync_in`  in  1  horizontal sync, active-high (monitored only)
- `v_sync_in`  in  1  vertical sync, active-high
- `cfg_we`  in  1  one-cycle write strobe for shadow configuration
- `cfg_mode`  in  2  processing mode to stage
- `cfg_thresh`  in  8  threshold to stage
- `cfg_busy`  out  1  staged config not yet applied
- `mode`  out  2  active mode driven to `vp`
- `thresh`  out  8  active threshold driven to `vp`
- `pix_de`  out  1  `de_in` delayed one cycle, aligned with `x_pos`/`y_pos`
- `x_pos`  out  H_BITS  column of pixel flagged by `pix_de`, 0-based
- `y_pos`  out  V_BITS  line of pixel flagged by `pix_de`, 0-based
- `frame_start`  out  1  one-cycle pulse at each v_sync rising edge
- `frame_width`  out  H_BITS  DE pixel count of last completed line
- `frame_height`  out  V_BITS  active line count of last completed frame
- `locked`  out  1  geometry stable for LOCK_FRAMES frames

## Operation

- Edge detect: registered `vs_d`, `de_d`. VS rise = `v_sync_in & ~vs_d`; DE fall = `~de_in & de_d`.
- Column counter: increments each cycle `de_in`=1, cleared on DE fall; saturates at 2^H_BITS-1.
- Line counter: increments on DE fall, cleared on VS rise; saturates at 2^V_BITS-1.
- On DE fall: `frame_width` <= column count (pixels in the line just ended).
- On VS rise: `frame_height` <= line count; line counter cleared; `frame_start` pulses; shadow applied if pending; lock FSM evaluated.
- Shadow config: `cfg_we` loads `sh_mode`/`sh_thresh`, sets `cfg_busy`. On VS rise with `cfg_busy`=1: `mode`/`thresh` <= shadow, `cfg_busy` cleared. Writes overwrite any pending shadow (last write wins).
- Simultaneous `cfg_we` and VS rise: previously staged value (if any) is applied; new write is captured into shadow and `cfg_busy` stays 1 until the next VS rise.
- Lock FSM (evaluated only on VS rise, `ref_w`/`ref_h` = stored geometry, `match_cnt` 4-bit):
  - SEARCH: reset state; first VS rise -> MEASURE (partial frame discarded).
  - MEASURE: next VS rise stores `ref_w`<=`frame_width`, `ref_h`<=line count, `match_cnt`<=0 -> LOCKING.
  - LOCKING: if (width, height) equals ref, `match_cnt`++; when it reaches LOCK_FRAMES -> LOCKED. On mismatch: reload ref, `match_cnt`<=0, stay.
  - LOCKED: match stays; mismatch -> reload ref, `match_cnt`<=0, LOCKING.
  - `locked` = 1 exactly in LOCKED.
- `h_sync_in` is not used for counting; DE alone defines lines.
- Reset (any time, including mid-frame): every register cleared, FSM -> SEARCH; effect is immediate (asynchronous).

## Timing

- Reset values: `cfg_busy`=0, `mode`=0, `thresh`=0, `pix_de`=0, `x_pos`=0, `y_pos`=0, `frame_start`=0, `frame_width`=0, `frame_height`=0, `locked`=0.
- `pix_de`/`x_pos`/`y_pos`: 1-cycle latency from `de_in`.
- `frame_start`, new `mode`/`thresh`, `frame_height`, `locked` change: visible 1 cycle after the first cycle `v_sync_in` is sampled high.
- `frame_width`: visible 1 cycle after the first cycle `de_in` is sampled low after a line.
- `cfg_busy`: high 1 cycle after `cfg_we`; low 1 cycle after the applying VS rise.
- `v_sync_in` held high for many cycles produces exactly one `frame_start`.

## Test plan

- Reset then 8x4 frames (8 DE cycles/line, 4 lines, VS between frames), LOCK_FRAMES=2 -> `frame_width`=8, `frame_height`=4, `locked` rises 1 cycle after the 4th VS rise (SEARCH, MEASURE, 2 matches).
- Coordinates: within a frame, `pix_de`=1 for 32 cycles; `x_pos` 0..7 per line, `y_pos` 0..3; last pixel reads (7,3).
- Config: `cfg_we` mid-frame with mode=2, thresh=0x80 -> `cfg_busy`=1, `mode`/`thresh` unchanged until 1 cycle after next VS rise, then 2/0x80 and `cfg_busy`=0.
- Collision: stage mode=1, then `cfg_we` mode=3 on VS-rise cycle -> `mode`=1 after that edge, `cfg_busy`=1, `mode`=3 after following VS rise.
- Geometry change while locked: switch to 6x4 -> `locked` drops 1 cycle after first 6x4 VS rise, reasserts after 2 further matching frames.
- Mid-frame `rst` pulse during line 2 -> all outputs 0 immediately; next VS rise only moves SEARCH->MEASURE, no `mode` change, `locked`=0.

Source files
------------

// File: rtl/vp_ctrl.sv
// Frame-synchronous controller for the vp pipeline: pixel coordinates, geometry
// measurement, lock detection and frame-boundary application of staged config.
module vp_ctrl #(
  parameter int unsigned H_BITS      = 11,
  parameter int unsigned V_BITS      = 11,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode,
  input  logic [7:0]        cfg_thresh,
  output logic              cfg_busy,
  output logic [1:0]        mode,
  output logic [7:0]        thresh,
  output logic              pix_de,
  output logic [H_BITS-1:0] x_pos,
  output logic [V_BITS-1:0] y_pos,
  output logic              frame_start,
  output logic [H_BITS-1:0] frame_width,
  output logic [V_BITS-1:0] frame_height,
  output logic              locked
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKING,
    ST_LOCKED
  } lock_state_e;

  lock_state_e       state_q, state_d;
  logic              vs_q, de_q;
  logic [H_BITS-1:0] col_q, col_d;
  logic [V_BITS-1:0] line_q, line_d;
  logic              pix_de_q, pix_de_d;
  logic [H_BITS-1:0] x_q, x_d;
  logic [V_BITS-1:0] y_q, y_d;
  logic              fs_q, fs_d;
  logic [H_BITS-1:0] fw_q, fw_d;
  logic [V_BITS-1:0] fh_q, fh_d;
  logic [1:0]        sh_mode_q, sh_mode_d;
  logic [7:0]        sh_thresh_q, sh_thresh_d;
  logic              busy_q, busy_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        thresh_q, thresh_d;
  logic [H_BITS-1:0] ref_w_q, ref_w_d;
  logic [V_BITS-1:0] ref_h_q, ref_h_d;
  logic [3:0]        match_q, match_d;

  logic vs_rise, de_fall, geo_match;
  logic unused_hsync;

  assign unused_hsync = h_sync_in;

  always_comb begin
    vs_rise   = v_sync_in & ~vs_q;
    de_fall   = ~de_in & de_q;
    geo_match = (fw_q == ref_w_q) && (line_q == ref_h_q);

    col_d = col_q;
    if (de_in) begin
      col_d = (col_q == '1) ? col_q : col_q + H_BITS'(1);
    end else if (de_fall) begin
      col_d = '0;
    end

    line_d = line_q;
    if (vs_rise) begin
      line_d = '0;
    end else if (de_fall && (line_q != '1)) begin
      line_d = line_q + V_BITS'(1);
    end

    pix_de_d = de_in;
    x_d      = de_in ? col_q  : x_q;
    y_d      = de_in ? line_q : y_q;
    fs_d     = vs_rise;
    fw_d     = de_fall ? col_q  : fw_q;
    fh_d     = vs_rise ? line_q : fh_q;

    // Apply happens before capture so a write on the VS-rise cycle stays pending.
    sh_mode_d   = sh_mode_q;
    sh_thresh_d = sh_thresh_q;
    busy_d      = busy_q;
    mode_d      = mode_q;
    thresh_d    = thresh_q;
    if (vs_rise && busy_q) begin
      mode_d   = sh_mode_q;
      thresh_d = sh_thresh_q;
      busy_d   = 1'b0;
    end
    if (cfg_we) begin
      sh_mode_d   = cfg_mode;
      sh_thresh_d = cfg_thresh;
      busy_d      = 1'b1;
    end

    state_d = state_q;
    ref_w_d = ref_w_q;
    ref_h_d = ref_h_q;
    match_d = match_q;
    if (vs_rise) begin
      case (state_q)
        ST_SEARCH: state_d = ST_MEASURE;
        ST_MEASURE: begin
          ref_w_d = fw_q;
          ref_h_d = line_q;
          match_d = '0;
          state_d = ST_LOCKING;
        end
        ST_LOCKING: begin
          if (geo_match) begin
            match_d = match_q + 4'd1;
            if (match_d == 4'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end else begin
            ref_w_d = fw_q;
            ref_h_d = line_q;
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!geo_match) begin
            ref_w_d = fw_q;
            ref_h_d = line_q;
            match_d = '0;
            state_d = ST_LOCKING;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      pix_de_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
      fw_q        <= '0;
      fh_q        <= '0;
      sh_mode_q   <= '0;
      sh_thresh_q <= '0;
      busy_q      <= 1'b0;
      mode_q      <= '0;
      thresh_q    <= '0;
      ref_w_q     <= '0;
      ref_h_q     <= '0;
      match_q     <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= v_sync_in;
      de_q        <= de_in;
      col_q       <= col_d;
      line_q      <= line_d;
      pix_de_q    <= pix_de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
      fw_q        <= fw_d;
      fh_q        <= fh_d;
      sh_mode_q   <= sh_mode_d;
      sh_thresh_q <= sh_thresh_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      ref_w_q     <= ref_w_d;
      ref_h_q     <= ref_h_d;
      match_q     <= match_d;
    end
  end

  assign cfg_busy     = busy_q;
  assign mode         = mode_q;
  assign thresh       = thresh_q;
  assign pix_de       = pix_de_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign frame_start  = fs_q;
  assign frame_width  = fw_q;
  assign frame_height = fh_q;
  assign locked       = (state_q == ST_LOCKED);

endmodule
